// File: rtl/sa_pkg.sv
// Shared definitions for the systolic array controller, array and SRAM wrappers.
package sa_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} sa_state_e;

  localparam int SA_N        = 4;
  localparam int SA_VW       = 8;
  localparam int SA_PIPE_LAT = 8;
endpackage

// File: rtl/valid_delay.sv
// Fixed-depth 1-bit valid delay line with an "no more valids to come" flag.
module valid_delay
  import sa_pkg::*;
#(
  parameter int DEPTH = SA_PIPE_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic vld,
  output logic vld_dly,
  output logic empty
);

  logic [DEPTH-1:0] sr_p1;
  logic [DEPTH:0]   line;

  assign line = {sr_p1, vld};

  always_ff @(posedge clk) begin
    if (rst) sr_p1 <= '0;
    else     sr_p1 <= line[DEPTH-1:0];
  end

  assign vld_dly = sr_p1[DEPTH-1];
  // Ignores the bit leaving this cycle, so DRAIN can exit on the last out_valid.
  assign empty   = ~|line[DEPTH-1:0];

endmodule

// File: rtl/systolic_ctrl.sv
// Sequences weight load, activation streaming and result write-back for one pass.
module systolic_ctrl
  import sa_pkg::*;
#(
  parameter int N        = SA_N,
  parameter int VW       = SA_VW,
  parameter int PIPE_LAT = SA_PIPE_LAT,
  parameter int WAW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [VW-1:0]  num_vec,
  output logic           busy,
  output logic           done,
  output logic           w_rd_en,
  output logic [WAW-1:0] w_rd_addr,
  output logic [N-1:0]   load_weight,
  output logic           a_rd_en,
  output logic [VW-1:0]  a_rd_addr,
  output logic           a_valid,
  output logic           out_valid,
  output logic [VW-1:0]  out_addr
);

  localparam logic [WAW:0] W_LAST = (WAW+1)'(N);

  sa_state_e     state, next;
  logic [WAW:0]  w_cnt;
  logic [VW-1:0] v_cnt;
  logic [VW-1:0] nv_q;
  logic          drain_empty;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next    = state;
    busy    = (state != IDLE);
    done    = (state == DONE);
    w_rd_en = (state == LOAD_W) && (w_cnt != W_LAST);
    a_rd_en = (state == STREAM);
    unique case (state)
      IDLE:    if (start) next = LOAD_W;
      // The extra LOAD_W cycle lets load_weight[N-1] land before streaming.
      LOAD_W:  if (w_cnt == W_LAST) next = (nv_q != '0) ? STREAM : DONE;
      STREAM:  if (v_cnt == nv_q - 1'b1) next = DRAIN;
      DRAIN:   if (drain_empty) next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  assign w_rd_addr = w_cnt[WAW-1:0];
  assign a_rd_addr = v_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_cnt       <= '0;
      v_cnt       <= '0;
      nv_q        <= '0;
      out_addr    <= '0;
      load_weight <= '0;
      a_valid     <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        nv_q     <= num_vec;
        w_cnt    <= '0;
        v_cnt    <= '0;
        out_addr <= '0;
      end
      if (w_rd_en)   w_cnt    <= w_cnt + 1'b1;
      if (a_rd_en)   v_cnt    <= v_cnt + 1'b1;
      if (out_valid) out_addr <= out_addr + 1'b1;
      // SRAM read latency of one cycle: strobes trail the read enables.
      load_weight <= w_rd_en ? (N'(1) << w_rd_addr) : '0;
      a_valid     <= a_rd_en;
    end
  end

  valid_delay #(.DEPTH(PIPE_LAT)) u_dly (
    .clk     (clk),
    .rst     (rst),
    .vld     (a_valid),
    .vld_dly (out_valid),
    .empty   (drain_empty)
  );

endmodule
